count_display_scan: RTL and testbench

//   Downstream display stage for the 4-bit up/down counter. Latches the count

---
 rtl/count_display_scan_if.sv | 20 ++
 rtl/count_display_scan.sv | 114 +++++++++++
 tb/tb_count_display_scan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/count_display_scan_if.sv
// Counter-to-display bus: latched count/direction inputs and the multiplexed
// 7-segment drive outputs.
interface count_display_scan_if;
  logic [3:0] val_in;
  logic       up_in;
  logic       upd_in;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit;

  modport master (
    output val_in, up_in, upd_in,
    input  seg, dp, digit
  );

  modport slave (
    input  val_in, up_in, upd_in,
    output seg, dp, digit
  );
endinterface

// File: rtl/count_display_scan.sv
// Display stage for the 4-bit up/down counter: hex count on digit0, U/d on
// digit1, blank digits 2-3, and a timed decimal-point flash after a wrap.
module count_display_scan #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned FLASH_SCANS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  count_display_scan_if.slave  bus
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned FW = $clog2(FLASH_SCANS + 1);

  typedef enum logic [1:0] {S0, S1, S2, S3} slot_t;

  slot_t          slot, slot_nxt;
  logic [DW-1:0]  div_cnt;
  logic [FW-1:0]  flash_cnt;
  logic [3:0]     val_q;
  logic           dir_q;
  logic           tick;
  logic           frame_end;
  logic           wrap;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick      = (div_cnt == DW'(SCAN_DIV - 1));
    frame_end = tick && (slot == S3);
    // Wrap compares the incoming value against the value held before this edge.
    wrap      = bus.upd_in &&
                (( bus.up_in && val_q == 4'hF && bus.val_in == 4'h0) ||
                 (!bus.up_in && val_q == 4'h0 && bus.val_in == 4'hF));
    slot_nxt  = slot;
    case (slot)
      S0: slot_nxt = S1;
      S1: slot_nxt = S2;
      S2: slot_nxt = S3;
      default: slot_nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q     <= '0;
      dir_q     <= 1'b1;
      div_cnt   <= '0;
      slot      <= S0;
      flash_cnt <= '0;
      bus.seg   <= '0;
      bus.dp    <= 1'b0;
      bus.digit <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        slot <= slot_nxt;

      if (bus.upd_in) begin
        val_q <= bus.val_in;
        dir_q <= bus.up_in;
      end

      // A reload on the frame-end edge takes priority over the decrement.
      if (wrap)
        flash_cnt <= FW'(FLASH_SCANS);
      else if (frame_end && flash_cnt != '0)
        flash_cnt <= flash_cnt - 1'b1;

      case (slot)
        S0: begin
          bus.digit <= 4'b0001;
          bus.seg   <= hex7(val_q);
          bus.dp    <= (flash_cnt != '0);
        end
        S1: begin
          bus.digit <= 4'b0010;
          bus.seg   <= dir_q ? 7'h3E : 7'h5E;
          bus.dp    <= 1'b0;
        end
        S2: begin
          bus.digit <= 4'b0100;
          bus.seg   <= '0;
          bus.dp    <= 1'b0;
        end
        default: begin
          bus.digit <= 4'b1000;
          bus.seg   <= '0;
          bus.dp    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan with a 4-cycle slot and 2-frame flash.
module tb_count_display_scan;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  count_display_scan_if bus();

  count_display_scan #(
    .SCAN_DIV    (4),
    .FLASH_SCANS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [3:0] ed, input logic [6:0] es,
                       input logic edp);
    checks++;
    assert ({bus.digit, bus.seg, bus.dp} === {ed, es, edp}) else begin
      errors++;
      $error("FAIL %s: got digit=%b seg=%h dp=%b, expected digit=%b seg=%h dp=%b",
             tag, bus.digit, bus.seg, bus.dp, ed, es, edp);
    end
  endtask

  // i is the cycle index within a 16-cycle scan frame.
  task automatic expect_slot(input string tag, input int i, input logic [6:0] s0,
                             input logic [6:0] s1, input logic dp0);
    case (i / 4)
      0:       check(tag, 4'b0001, s0, dp0);
      1:       check(tag, 4'b0010, s1, 1'b0);
      2:       check(tag, 4'b0100, 7'h00, 1'b0);
      default: check(tag, 4'b1000, 7'h00, 1'b0);
    endcase
  endtask

  // One full frame of checks; optionally strobes an update at cycle upd_at
  // (14 lands the capture on the frame-end edge, 13 one edge earlier).
  task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                       input logic dp0, input int upd_at, input logic [3:0] v,
                       input logic u);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expect_slot(tag, i, s0, s1, dp0);
      bus.upd_in = (i == upd_at);
      bus.val_in = v;
      bus.up_in  = u;
    end
  endtask

  initial begin
    logic [3:0] q, pv;
    logic       dq, pu, pend;
    errors = 0;
    checks = 0;
    rst        = 1'b1;
    bus.upd_in = 1'b0;
    bus.val_in = 4'h0;
    bus.up_in  = 1'b0;

    @(negedge clk);
    check("rst_a", 4'b0000, 7'h00, 1'b0);
    @(negedge clk);
    check("rst_b", 4'b0000, 7'h00, 1'b0);
    rst = 1'b0;

    // Idle scan, then load A counting down.
    frame("idle0", 7'h3F, 7'h3E, 1'b0, -1, 4'h0, 1'b0);
    frame("idle1", 7'h3F, 7'h3E, 1'b0, 14, 4'hA, 1'b0);
    frame("valA",  7'h77, 7'h5E, 1'b0, 14, 4'hF, 1'b1);

    // F->0 up wraps: dp lit for exactly two frames.
    frame("valF",     7'h71, 7'h3E, 1'b0, 14, 4'h0, 1'b1);
    frame("upwrap1",  7'h3F, 7'h3E, 1'b1, -1, 4'h0, 1'b1);
    frame("upwrap2",  7'h3F, 7'h3E, 1'b1, -1, 4'h0, 1'b1);
    frame("upwrap_off", 7'h3F, 7'h3E, 1'b0, 14, 4'hF, 1'b1);

    // 0->F up and F->0 down are not wraps.
    frame("nowrap_up", 7'h71, 7'h3E, 1'b0, 14, 4'h0, 1'b0);
    frame("nowrap_dn", 7'h3F, 7'h5E, 1'b0, 14, 4'hF, 1'b0);

    // 0->F down wraps; a second wrap on the frame-end edge reloads the flash.
    frame("dnwrap1",   7'h71, 7'h5E, 1'b1, 14, 4'h0, 1'b1);
    frame("rewrap1",   7'h3F, 7'h3E, 1'b1, -1, 4'h0, 1'b1);
    frame("rewrap2",   7'h3F, 7'h3E, 1'b1, -1, 4'h0, 1'b1);
    frame("rewrap_off", 7'h3F, 7'h3E, 1'b0, 13, 4'hF, 1'b0);

    // Wrap one edge before frame end: decremented at once, one lit frame.
    frame("midwrap",     7'h71, 7'h5E, 1'b1, -1, 4'h0, 1'b0);
    frame("midwrap_off", 7'h71, 7'h5E, 1'b0, 14, 4'h0, 1'b0);
    frame("pre_rst",     7'h3F, 7'h5E, 1'b0, 14, 4'hF, 1'b0);

    // Reset in slot S2 while flashing.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_slot("flash_s2", i, 7'h71, 7'h5E, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", 4'b0000, 7'h00, 1'b0);
    rst = 1'b0;
    frame("post_rst", 7'h3F, 7'h3E, 1'b0, -1, 4'h0, 1'b0);

    // Update every cycle with values 0..F counting down.
    q    = 4'h0;
    dq   = 1'b1;
    pend = 1'b0;
    pv   = 4'h0;
    pu   = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      expect_slot("scan_upd", n % 16, hex_tab[q], dq ? 7'h3E : 7'h5E, 1'b0);
      if (pend) begin
        q  = pv;
        dq = pu;
      end
      pend = (n < 31);
      pv   = 4'(n % 16);
      pu   = 1'b0;
      bus.upd_in = pend;
      bus.val_in = pv;
      bus.up_in  = pu;
    end
    frame("after_scan", 7'h79, 7'h5E, 1'b0, -1, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
